// File: rtl/manager_burst_if.sv
// ---------------------------------------------------------------------------
// manager_burst_if
//
// Bundles the UART-side and flash-side signals of the burst command manager.
//   master : the manager itself (drives RS_DATAIN, RS_TRG_WRITE, FL_ADDR,
//            fl_data_out, FL_FLOW, FL_TRG, BUSY)
//   slave  : the surrounding UART core / flash byte controller
//
//   RS_DATAOUT   byte from the UART receiver, valid while RS_DONE is high
//   RS_DONE      one-cycle strobe per received byte
//   RS_DATAIN    byte to transmit, valid with RS_TRG_WRITE
//   RS_TRG_WRITE one-cycle transmit strobe
//   RS_TX_BUSY   transmitter busy level
//   FL_ADDR      flash byte address (8*ADDR_BYTES bits)
//   fl_data_out  write data to flash
//   fl_data_in   read data from flash, valid while FL_STATUS is high
//   FL_FLOW      1 = write, 0 = read
//   FL_TRG       one-cycle start strobe to the flash controller
//   FL_STATUS    one-cycle done strobe from the flash controller
//   BUSY         manager is not idle
// ---------------------------------------------------------------------------
interface manager_burst_if #(
  parameter int ADDR_BYTES = 1
);
  logic [7:0]              RS_DATAOUT;
  logic                    RS_DONE;
  logic [7:0]              RS_DATAIN;
  logic                    RS_TRG_WRITE;
  logic                    RS_TX_BUSY;
  logic [8*ADDR_BYTES-1:0] FL_ADDR;
  logic [7:0]              fl_data_out;
  logic [7:0]              fl_data_in;
  logic                    FL_FLOW;
  logic                    FL_TRG;
  logic                    FL_STATUS;
  logic                    BUSY;

  modport master (
    input  RS_DATAOUT, RS_DONE, RS_TX_BUSY, fl_data_in, FL_STATUS,
    output RS_DATAIN, RS_TRG_WRITE, FL_ADDR, fl_data_out, FL_FLOW, FL_TRG, BUSY
  );

  modport slave (
    output RS_DATAOUT, RS_DONE, RS_TX_BUSY, fl_data_in, FL_STATUS,
    input  RS_DATAIN, RS_TRG_WRITE, FL_ADDR, fl_data_out, FL_FLOW, FL_TRG, BUSY
  );
endinterface

// File: rtl/manager_burst.sv
// ---------------------------------------------------------------------------
// manager_burst
//
// Parses UART command frames  cmd, addr[ADDR_BYTES] (MSB first), len, data[len]
// ('W' = 0x57 write, 'R' = 0x52 read), runs a back-to-back burst of len byte
// transfers against the flash byte controller through a local buffer and
// answers 'K' (plus the read bytes) or 'E' through the UART transmitter.
//
// Ports
//   CLK_50MHZ : the only clock
//   RST       : asynchronous active-low reset
//   bus       : manager_burst_if.master (UART + flash handshakes, BUSY)
// Parameters
//   ADDR_BYTES (1..4), MAX_BURST (1..255), FL_TIMEOUT, RX_TIMEOUT (cycles)
// ---------------------------------------------------------------------------
module manager_burst #(
  parameter int ADDR_BYTES = 1,
  parameter int MAX_BURST  = 16,
  parameter int FL_TIMEOUT = 1024,
  parameter int RX_TIMEOUT = 500000
) (
  input logic           CLK_50MHZ,
  input logic           RST,
  manager_burst_if.master bus
);
  localparam int AW = 8 * ADDR_BYTES;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int FW = $clog2(FL_TIMEOUT + 1);
  localparam int RW = $clog2(RX_TIMEOUT + 1);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_E = 8'h45;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_LEN, S_WDATA, S_FL_START, S_FL_WAIT,
    S_TX_HDR, S_TX_DATA, S_TX_ERR
  } state_t;

  state_t        state, state_n;
  logic [7:0]    idx, idx_n;          // address-byte count, then buffer index
  logic [7:0]    len, len_n;
  logic [AW-1:0] addr, addr_n;
  logic          cmd_w, cmd_w_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic          trg, trg_n;
  logic          tx, tx_n;
  logic          guard;
  logic          busy;
  logic [7:0]    txd, txd_n;
  logic [7:0]    fdo, fdo_n;

  logic          buf_we;
  logic [BW-1:0] buf_wa;
  logic [7:0]    buf_wd;
  logic [7:0]    buf_mem [MAX_BURST];

  logic          tx_ok;
  logic          rx_expired;

  // A transmit strobe is only decided when the UART is idle and neither the
  // strobe cycle itself nor the guard cycle after it is in progress; the
  // guard covers the cycle in which the UART has not yet raised its busy flag.
  assign tx_ok      = !bus.RS_TX_BUSY && !tx && !guard;
  assign rx_expired = (rcnt == RW'(RX_TIMEOUT - 1));

  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len;
    addr_n  = addr;
    cmd_w_n = cmd_w;
    fcnt_n  = fcnt;
    rcnt_n  = rcnt;
    tx_n    = 1'b0;
    txd_n   = txd;
    fdo_n   = fdo;
    buf_we  = 1'b0;
    buf_wa  = idx[BW-1:0];
    buf_wd  = bus.RS_DATAOUT;

    unique case (state)
      S_IDLE: begin
        if (bus.RS_DONE) begin
          if (bus.RS_DATAOUT == CMD_W || bus.RS_DATAOUT == CMD_R) begin
            cmd_w_n = (bus.RS_DATAOUT == CMD_W);
            idx_n   = '0;
            rcnt_n  = '0;
            state_n = S_ADDR;
          end else begin
            state_n = S_TX_ERR;
          end
        end
      end

      // A byte arriving in the expiry cycle is accepted: RS_DONE is tested first.
      S_ADDR: begin
        if (bus.RS_DONE) begin
          addr_n = (addr << 8) | AW'(bus.RS_DATAOUT);
          idx_n  = idx + 8'd1;
          rcnt_n = '0;
          if (idx_n == 8'(ADDR_BYTES)) begin
            idx_n   = '0;
            state_n = S_LEN;
          end
        end else if (rx_expired) begin
          state_n = S_TX_ERR;
        end else begin
          rcnt_n = rcnt + RW'(1);
        end
      end

      S_LEN: begin
        if (bus.RS_DONE) begin
          rcnt_n = '0;
          if (bus.RS_DATAOUT == 8'd0 || bus.RS_DATAOUT > 8'(MAX_BURST)) begin
            state_n = S_TX_ERR;
          end else begin
            len_n   = bus.RS_DATAOUT;
            idx_n   = '0;
            state_n = cmd_w ? S_WDATA : S_FL_START;
          end
        end else if (rx_expired) begin
          state_n = S_TX_ERR;
        end else begin
          rcnt_n = rcnt + RW'(1);
        end
      end

      S_WDATA: begin
        if (bus.RS_DONE) begin
          buf_we = 1'b1;
          idx_n  = idx + 8'd1;
          rcnt_n = '0;
          if (idx_n == len) begin
            idx_n   = '0;
            state_n = S_FL_START;
          end
        end else if (rx_expired) begin
          state_n = S_TX_ERR;
        end else begin
          rcnt_n = rcnt + RW'(1);
        end
      end

      S_FL_START: begin
        fcnt_n  = '0;
        state_n = S_FL_WAIT;
      end

      // FL_STATUS is tested before the timeout so a late done still wins.
      S_FL_WAIT: begin
        if (bus.FL_STATUS) begin
          if (!cmd_w) begin
            buf_we = 1'b1;
            buf_wd = bus.fl_data_in;
          end
          idx_n  = idx + 8'd1;
          addr_n = addr + AW'(1);
          if (idx_n == len) begin
            idx_n   = '0;
            state_n = S_TX_HDR;
          end else begin
            state_n = S_FL_START;
          end
        end else if (fcnt == FW'(FL_TIMEOUT - 1)) begin
          state_n = S_TX_ERR;
        end else begin
          fcnt_n = fcnt + FW'(1);
        end
      end

      S_TX_HDR: begin
        if (tx_ok) begin
          tx_n    = 1'b1;
          txd_n   = RSP_K;
          state_n = cmd_w ? S_IDLE : S_TX_DATA;
        end
      end

      S_TX_DATA: begin
        if (tx_ok) begin
          tx_n  = 1'b1;
          txd_n = buf_mem[idx[BW-1:0]];
          idx_n = idx + 8'd1;
          if (idx_n == len) begin
            idx_n   = '0;
            state_n = S_IDLE;
          end
        end
      end

      S_TX_ERR: begin
        if (tx_ok) begin
          tx_n    = 1'b1;
          txd_n   = RSP_E;
          state_n = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase

    // FL_TRG and its write data are registered on entry to FL_START. The
    // bypass covers a one-byte write, whose only byte lands in the buffer on
    // the same edge.
    trg_n = (state_n == S_FL_START);
    if (trg_n) begin
      fdo_n = (buf_we && buf_wa == idx_n[BW-1:0]) ? buf_wd : buf_mem[idx_n[BW-1:0]];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
      idx   <= '0;
      len   <= '0;
      addr  <= '0;
      cmd_w <= 1'b0;
      fcnt  <= '0;
      rcnt  <= '0;
      trg   <= 1'b0;
      tx    <= 1'b0;
      guard <= 1'b0;
      busy  <= 1'b0;
      txd   <= '0;
      fdo   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      len   <= len_n;
      addr  <= addr_n;
      cmd_w <= cmd_w_n;
      fcnt  <= fcnt_n;
      rcnt  <= rcnt_n;
      trg   <= trg_n;
      tx    <= tx_n;
      guard <= tx;
      busy  <= (state_n != S_IDLE);
      txd   <= txd_n;
      fdo   <= fdo_n;
    end
  end

  // NOTE: the buffer has no reset; every entry is written before it is read
  // within a burst, so clearing it would add nothing.
  always_ff @(posedge CLK_50MHZ) begin
    if (buf_we) buf_mem[buf_wa] <= buf_wd;
  end

  assign bus.RS_DATAIN    = txd;
  assign bus.RS_TRG_WRITE = tx;
  assign bus.FL_ADDR      = addr;
  assign bus.fl_data_out  = fdo;
  assign bus.FL_FLOW      = cmd_w;
  assign bus.FL_TRG       = trg;
  assign bus.BUSY         = busy;
endmodule

// File: doc/manager_burst.md
# manager_burst

Parametrised successor of the serial-to-flash command manager. It parses multi-byte command frames from the UART receiver and executes burst reads or writes of 1..MAX_BURST bytes against the flash byte controller through a local buffer. It returns an ACK/NAK-framed response through the UART transmitter. It sits between the UART core and the flash controller at the top level, replacing the single-byte RX/flash/TX FSM trio.

## Interface

**Parameters**
- ADDR_BYTES, 1: address bytes per frame (1..4), MSB first; FL_ADDR width = 8*ADDR_BYTES.
- MAX_BURST, 16: buffer depth and maximum burst length (1..255).
- FL_TIMEOUT, 1024: cycles to wait for FL_STATUS before aborting.
- RX_TIMEOUT, 500000: maximum idle cycles between bytes of one frame.

**Ports**
- CLK_50MHZ, in, 1: the only clock.
- RST, in, 1: asynchronous, active-low reset.
- RS_DATAOUT, in, 8: received byte; valid while RS_DONE is high.
- RS_DONE, in, 1: one-cycle strobe per received byte.
- RS_DATAIN, out, 8: byte to transmit.
- RS_TRG_WRITE, out, 1: one-cycle transmit strobe.
- RS_TX_BUSY, in, 1: UART transmitter busy (level).
- FL_ADDR, out, 8*ADDR_BYTES: flash byte address.
- fl_data_out, out, 8: write data to flash.
- fl_data_in, in, 8: read data from flash; valid while FL_STATUS is high.
- FL_FLOW, out, 1: 1 = write, 0 = read.
- FL_TRG, out, 1: one-cycle start strobe to the flash controller.
- FL_STATUS, in, 1: one-cycle done strobe from the flash controller.
- BUSY, out, 1: high in every state except IDLE.

## Operation

**Frame format:** cmd byte, then ADDR_BYTES address bytes, then length N, then N data bytes (write only).
- Commands: 0x57 'W' (write) and 0x52 'R' (read).

**Responses**
- Success: 0x4B 'K'. A read response is 'K' followed by N buffer bytes.
- Error: 0x45 'E'.

**State machine**
- IDLE: an RS_DONE byte equal to 'R' or 'W' latches the command and goes to ADDR. Any other byte goes to TX_ERR.
- ADDR: shifts in ADDR_BYTES bytes, then goes to LEN.
- LEN: if N==0 or N>MAX_BURST, go to TX_ERR. Otherwise latch N and clear the index. A write goes to WDATA; a read goes to FL_START.
- WDATA: stores each byte at buf[idx] and increments idx. When idx reaches N, go to FL_START.
- FL_START: FL_TRG=1 for one cycle; the timeout counter is cleared. Go to FL_WAIT.
- FL_WAIT, on FL_STATUS:
  - A read stores fl_data_in into buf[idx].
  - Then idx++ and addr++.
  - If idx==N, go to TX_HDR; otherwise go to FL_START.
  - If the timeout counter reaches FL_TIMEOUT first, go to TX_ERR.
- TX_HDR: sends 'K'. A read goes to TX_DATA; a write goes to IDLE.
- TX_DATA: sends buf[0..N-1], then goes to IDLE.
- TX_ERR: sends 'E', then goes to IDLE.

**Field behaviour**
- The address increments per byte and wraps modulo 2^(8*ADDR_BYTES).
- FL_FLOW = command is 'W'.
- fl_data_out = buf[idx].

**Receive timeout:** in ADDR, LEN or WDATA, RX_TIMEOUT cycles without RS_DONE goes to TX_ERR. The counter restarts on every RS_DONE.

**Ignored inputs**
- RS_DONE is ignored in FL_*, TX_* and TX_ERR; those bytes are dropped.
- FL_STATUS is ignored outside FL_WAIT.

**Reset values:** all outputs 0, the FSM in IDLE, counters and index cleared. Buffer contents are undefined.
- Reset mid-burst aborts immediately: no response is sent and no further FL_TRG is issued.

## Timing

- Every output is registered.
- FL_TRG rises on the edge after the cycle holding the final frame byte's RS_DONE (write), or the length byte's RS_DONE (read).
- FL_ADDR, FL_FLOW and fl_data_out are stable from the FL_TRG cycle until the FL_STATUS cycle inclusive.
- The next FL_TRG comes exactly 1 cycle after an FL_STATUS cycle, so bytes are issued back to back.
- Transmit handshake:
  - RS_TRG_WRITE pulses only when RS_TX_BUSY is low, with RS_DATAIN valid in the same cycle.
  - After a strobe, RS_TX_BUSY is ignored for 1 guard cycle; the next strobe waits for RS_TX_BUSY low.
- The response starts no earlier than 1 cycle after the final FL_STATUS.
- If FL_STATUS and the timeout expiry fall in the same cycle, FL_STATUS wins and no error is reported.
- If RS_DONE and RX-timeout expiry fall in the same cycle, the byte is accepted.

## Test plan

- ADDR_BYTES=1: frame 57 10 02 AA 55 with FL_STATUS 3 cycles after each FL_TRG -> two FL_TRG with FL_FLOW=1 (addr 0x10 data 0xAA, addr 0x11 data 0x55), then TX 'K'.
- ADDR_BYTES=2: frame 52 FF FF 03, flash returning 11 22 33 -> FL_ADDR FFFF, 0000, 0001 (wrap); TX 4B 11 22 33 with correct RS_TX_BUSY pacing.
- Length 0, and length MAX_BURST+1 -> no FL_TRG; TX 45 only. An unknown cmd byte 0x41 -> TX 45.
- FL_STATUS withheld -> exactly FL_TIMEOUT cycles later TX 45. FL_STATUS at the expiry cycle -> burst continues.
- Frame stalls after the address byte for RX_TIMEOUT cycles -> TX 45 and return to IDLE. Extra RS_DONE bytes during a burst are ignored and the burst result is unchanged.
- RST low during the second FL_WAIT of a 4-byte write -> all outputs 0 immediately, no TX. A following frame 57 00 01 5A executes normally.
